alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a single combinational 32-bit ALU instance between two requesters, for example the EX-stage datapath (port 0) and a branch/compare helper (port 1).
- Accepts one operation at a time through valid/ready handshakes and drives the shared ALU from registered operands.
- Captures the ALU result and Zero flag into a response register.
- Returns the response to the granted requester with a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU datapath.
- CTRL_W, 5, ALU control code width (5'b00001 add, 5'b00010 sub, ...).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req0Valid  input  1  requester 0 presents an operation.
- Req0Ready  output  1  requester 0 operation accepted this cycle.
- Req0Ctrl  input  CTRL_W  requester 0 ALU control code.
- Req0A, Req0B  input  DATA_W  requester 0 operands.
- Req1Valid, Req1Ready, Req1Ctrl, Req1A, Req1B  as above, for requester 1.
- Rsp0Valid  output  1  result pending for requester 0.
- Rsp0Ready  input  1  requester 0 consumes the result.
- Rsp1Valid, Rsp1Ready  as above, for requester 1.
- RspResult  output  DATA_W  registered ALU result; shared by both response ports.
- RspZero  output  1  registered ALU Zero flag.
- AluControl  output  CTRL_W  to the shared ALU.
- AluA, AluB  output  DATA_W  to the shared ALU.
- AluResult  input  DATA_W  from the shared ALU.
- AluZero  input  1  from the shared ALU.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, named Reset.
- Reset state: IDLE, priority pointer = 0.
- Outputs held at reset:
  - Req0Ready = Req1Ready = 0; Rsp0Valid = Rsp1Valid = 0.
  - RspResult = 0, RspZero = 0.
  - AluControl = 0, AluA = AluB = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Ready is combinational and asserted only to the winner: the sole valid requester, or, if both are valid, the one selected by the pointer.
  - On a handshake (valid & ready): latch Ctrl/A/B into operand registers, record grant owner, go to EXEC.
  - Pointer := the other requester after every grant, including grants made with no contention.
  - No valid requester: stay in IDLE, pointer unchanged.
- EXEC:
  - AluControl/AluA/AluB are driven from the operand registers; these registers are stable for the whole state.
  - At the end of the cycle capture AluResult -> RspResult and AluZero -> RspZero, then go to RESP.
  - Both Ready outputs = 0.
- RESP:
  - RspNValid = 1 for the owner only; the other RspValid = 0.
  - Hold RspResult/RspZero until RspNReady = 1, then go to IDLE.
  - Both Ready outputs = 0; no new grant is made in the same cycle as the response handshake.
- Latency and throughput:
  - Accept at cycle N -> RspValid high from cycle N+2.
  - Maximum throughput is 1 operation per 3 cycles with immediate RspReady.
- Operand and response register behaviour:
  - The AluControl/AluA/AluB registers retain their last values outside EXEC; they are not cleared.
  - RspResult/RspZero retain their last value after the response handshake.
- Requester rules:
  - Changing Ctrl/A/B after acceptance has no effect.
  - Dropping Valid before Ready is legal and cancels that request.
  - Holding RspReady high early is legal; the response handshake completes on the first RESP cycle.
  - A RspReady from the non-owner is ignored.
- Starvation bound: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- Reset mid-operation (EXEC or RESP): the result is discarded, the FSM returns to IDLE, all outputs take their reset values, and no response is delivered.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- Defined:
  - Adds outputs Grant0Count and Grant1Count (16 bits each).
  - Each counter increments on its requester's request handshake and saturates at 16'hFFFF.
  - Both counters are cleared by Reset.
  - Adds output Contention (1 bit), registered: high for one cycle after any IDLE cycle in which both Valids were high.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then Req0Valid=1, Ctrl=5'b00001, A=5, B=7 -> Req0Ready=1 in cycle N; AluA=5, AluB=7 in N+1; Rsp0Valid=1 with RspResult=12, RspZero=0 in N+2; Rsp1Valid stays 0.
- Req1 sub with A=9, B=9 (Ctrl=5'b00010) -> Rsp1Valid, RspResult=0, RspZero=1.
- Both requesters valid continuously, RspReady tied high, 6 operations -> grant order 0,1,0,1,0,1; each response arrives on the matching port; one operation per 3 cycles.
- Response backpressure: hold Rsp0Ready=0 for 5 cycles while Req1Valid=1 -> Req1Ready stays 0 and RspResult stays stable; Rsp0Ready=1 -> IDLE, then Req1 is granted the next cycle.
- Assert Reset in the EXEC cycle -> next cycle both RspValids=0, RspResult=0, pointer=0; Req0 and Req1 valid together -> Req0 granted first.
- With ALU_SHARE_ARB_STATS_EN defined: 3 Req0 grants and 2 Req1 grants with overlap -> Grant0Count=3, Grant1Count=2; Contention pulses once per overlapping IDLE cycle; preloaded Grant0Count=16'hFFFF stays 16'hFFFF after a further Req0 grant.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one combinational ALU
//            between two requesters (IDLE -> EXEC -> RESP per operation).
// Options  : ALU_SHARE_ARB_STATS_EN adds grant counters and a contention flag.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [CTRL_W-1:0] Req0Ctrl,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req0B,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [CTRL_W-1:0] Req1Ctrl,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req1B,
    output logic              Rsp0Valid,
    input  logic              Rsp0Ready,
    output logic              Rsp1Valid,
    input  logic              Rsp1Ready,
    output logic [DATA_W-1:0] RspResult,
    output logic              RspZero,
    output logic [CTRL_W-1:0] AluControl,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              AluZero
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]       Grant0Count,
    output logic [15:0]       Grant1Count,
    output logic              Contention
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_ptr;      // 0: requester 0 wins a tie, 1: requester 1
    logic                r_owner;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                w_grant0;
    logic                w_grant1;

    always_comb begin
        w_next_state = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        Rsp0Valid    = 1'b0;
        Rsp1Valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by Reset so no handshake is offered while reset is applied.
                if (!Reset) begin
                    w_grant0 = Req0Valid & (~Req1Valid | ~r_ptr);
                    w_grant1 = Req1Valid & (~Req0Valid |  r_ptr);
                end
                if (w_grant0 || w_grant1) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                Rsp0Valid = ~Reset & ~r_owner;
                Rsp1Valid = ~Reset &  r_owner;
                if (r_owner ? Rsp1Ready : Rsp0Ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        Req0Ready = w_grant0;
        Req1Ready = w_grant1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant0 || w_grant1) begin
                r_ctrl  <= w_grant1 ? Req1Ctrl : Req0Ctrl;
                r_a     <= w_grant1 ? Req1A    : Req0A;
                r_b     <= w_grant1 ? Req1B    : Req0B;
                r_owner <= w_grant1;
                r_ptr   <= w_grant0;
            end
            if (r_state == S_EXEC) begin
                r_result <= AluResult;
                r_zero   <= AluZero;
            end
        end
    end

    assign AluControl = r_ctrl;
    assign AluA       = r_a;
    assign AluB       = r_b;
    assign RspResult  = r_result;
    assign RspZero    = r_zero;

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0] r_g0_cnt;
    logic [15:0] r_g1_cnt;
    logic        r_contention;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_g0_cnt     <= '0;
            r_g1_cnt     <= '0;
            r_contention <= 1'b0;
        end else begin
            if (w_grant0 && (r_g0_cnt != 16'hFFFF)) begin
                r_g0_cnt <= r_g0_cnt + 16'd1;
            end
            if (w_grant1 && (r_g1_cnt != 16'hFFFF)) begin
                r_g1_cnt <= r_g1_cnt + 16'd1;
            end
            r_contention <= (r_state == S_IDLE) && Req0Valid && Req1Valid;
        end
    end

    assign Grant0Count = r_g0_cnt;
    assign Grant1Count = r_g1_cnt;
    assign Contention  = r_contention;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench: directed scenarios plus random traffic
//            compared every cycle against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 5;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Req0Valid, Req1Valid, Req0Ready, Req1Ready;
    logic [CTRL_W-1:0] Req0Ctrl, Req1Ctrl, AluControl;
    logic [DATA_W-1:0] Req0A, Req0B, Req1A, Req1B;
    logic              Rsp0Valid, Rsp1Valid, Rsp0Ready, Rsp1Ready;
    logic [DATA_W-1:0] RspResult, AluA, AluB, AluResult;
    logic              RspZero, AluZero;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [15:0]       Grant0Count, Grant1Count;
    logic              Contention;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Ctrl(Req0Ctrl),
        .Req0A(Req0A), .Req0B(Req0B),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Ctrl(Req1Ctrl),
        .Req1A(Req1A), .Req1B(Req1B),
        .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready),
        .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready),
        .RspResult(RspResult), .RspZero(RspZero),
        .AluControl(AluControl), .AluA(AluA), .AluB(AluB),
        .AluResult(AluResult), .AluZero(AluZero)
`ifdef ALU_SHARE_ARB_STATS_EN
        , .Grant0Count(Grant0Count), .Grant1Count(Grant1Count), .Contention(Contention)
`endif
    );

    function automatic logic [DATA_W-1:0] alu_fn(input logic [CTRL_W-1:0] c,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (c)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Environment: the shared combinational ALU
    assign AluResult = alu_fn(AluControl, AluA, AluB);
    assign AluZero   = (AluResult == '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_age: cycles since the pending operation was accepted (0 = none pending)
    bit                m_on = 1'b0;
    int                m_age = 0;
    bit                m_pri = 1'b0;
    bit                m_owner = 1'b0;
    logic [CTRL_W-1:0] m_ctrl = '0;
    logic [DATA_W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic              m_zero = 1'b0;
    int                m_g0 = 0, m_g1 = 0;
    logic              m_cont = 1'b0;

    function automatic logic want0();
        return !Reset && m_age == 0 && Req0Valid && (!Req1Valid || !m_pri);
    endfunction
    function automatic logic want1();
        return !Reset && m_age == 0 && Req1Valid && (!Req0Valid || m_pri);
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            m_on <= 1'b1; m_age <= 0; m_pri <= 1'b0; m_owner <= 1'b0;
            m_ctrl <= '0; m_a <= '0; m_b <= '0; m_res <= '0; m_zero <= 1'b0;
            m_g0 <= 0; m_g1 <= 0; m_cont <= 1'b0;
        end else begin
            m_cont <= (m_age == 0) && Req0Valid && Req1Valid;
            if (want0() || want1()) begin
                m_owner <= want1();
                m_pri   <= !want1();
                m_ctrl  <= want1() ? Req1Ctrl : Req0Ctrl;
                m_a     <= want1() ? Req1A : Req0A;
                m_b     <= want1() ? Req1B : Req0B;
                m_age   <= 1;
                if (want0()) m_g0 <= (m_g0 < 65535) ? m_g0 + 1 : m_g0;
                if (want1()) m_g1 <= (m_g1 < 65535) ? m_g1 + 1 : m_g1;
            end else if (m_age == 1) begin
                m_res  <= alu_fn(m_ctrl, m_a, m_b);
                m_zero <= (alu_fn(m_ctrl, m_a, m_b) == '0);
                m_age  <= 2;
            end else if (m_age == 2 && (m_owner ? Rsp1Ready : Rsp0Ready)) begin
                m_age <= 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (m_on) begin
            chk("m_req0_ready", 32'(Req0Ready), 32'(want0()));
            chk("m_req1_ready", 32'(Req1Ready), 32'(want1()));
            chk("m_rsp0_valid", 32'(Rsp0Valid), 32'(!Reset && m_age == 2 && !m_owner));
            chk("m_rsp1_valid", 32'(Rsp1Valid), 32'(!Reset && m_age == 2 && m_owner));
            chk("m_rsp_result", RspResult, m_res);
            chk("m_rsp_zero", 32'(RspZero), 32'(m_zero));
            chk("m_alu_ctrl", 32'(AluControl), 32'(m_ctrl));
            chk("m_alu_a", AluA, m_a);
            chk("m_alu_b", AluB, m_b);
`ifdef ALU_SHARE_ARB_STATS_EN
            chk("m_grant0_count", 32'(Grant0Count), 32'(m_g0));
            chk("m_grant1_count", 32'(Grant1Count), 32'(m_g1));
            chk("m_contention", 32'(Contention), 32'(m_cont));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    int gown[$];
    int gcyc[$];

    initial begin
        Reset = 1'b1;
        Req0Valid = 0; Req1Valid = 0; Rsp0Ready = 1; Rsp1Ready = 1;
        Req0Ctrl = '0; Req1Ctrl = '0; Req0A = '0; Req0B = '0; Req1A = '0; Req1B = '0;
        step(); step();
        @(negedge Clk);
        chk("rst_req0_ready", 32'(Req0Ready), 32'd0);
        chk("rst_rsp0_valid", 32'(Rsp0Valid), 32'd0);
        chk("rst_rsp_result", RspResult, 32'd0);
        chk("rst_alu_a", AluA, 32'd0);
        step();
        Reset = 1'b0;

        // Req0 add 5+7: ready at N, operands at N+1, response at N+2
        Req0Valid = 1; Req0Ctrl = 5'd1; Req0A = 32'd5; Req0B = 32'd7;
        @(negedge Clk);
        chk("add_req0_ready", 32'(Req0Ready), 32'd1);
        step();
        Req0Valid = 0; Req0A = 32'hDEAD;
        @(negedge Clk);
        chk("add_alu_a", AluA, 32'd5);
        chk("add_alu_b", AluB, 32'd7);
        chk("add_alu_ctrl", 32'(AluControl), 32'd1);
        step();
        @(negedge Clk);
        chk("add_rsp0_valid", 32'(Rsp0Valid), 32'd1);
        chk("add_rsp1_valid", 32'(Rsp1Valid), 32'd0);
        chk("add_result", RspResult, 32'd12);
        chk("add_zero", 32'(RspZero), 32'd0);
        step();

        // Req1 sub 9-9 -> zero
        Req1Valid = 1; Req1Ctrl = 5'd2; Req1A = 32'd9; Req1B = 32'd9;
        @(negedge Clk);
        chk("sub_req1_ready", 32'(Req1Ready), 32'd1);
        step();
        Req1Valid = 0;
        step();
        @(negedge Clk);
        chk("sub_rsp1_valid", 32'(Rsp1Valid), 32'd1);
        chk("sub_rsp0_valid", 32'(Rsp0Valid), 32'd0);
        chk("sub_result", RspResult, 32'd0);
        chk("sub_zero", 32'(RspZero), 32'd1);
        step();

        // Continuous contention: grants alternate, one per 3 cycles
        Req0Valid = 1; Req1Valid = 1;
        Req0Ctrl = 5'd1; Req1Ctrl = 5'd2;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clk);
            if (Req0Ready) begin gown.push_back(0); gcyc.push_back(cyc); end
            if (Req1Ready) begin gown.push_back(1); gcyc.push_back(cyc); end
            if (gown.size() >= 6) break;
            step();
            Req0A = $urandom; Req0B = $urandom; Req1A = $urandom; Req1B = $urandom;
        end
        step();
        Req0Valid = 0; Req1Valid = 0;
        chk("rr_grant_total", 32'(gown.size()), 32'd6);
        for (int i = 0; i < gown.size(); i++) begin
            chk("rr_grant_order", 32'(gown[i]), 32'(i % 2));
            if (i > 0) chk("rr_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        step(); step();

        // Response backpressure on port 0 while requester 1 waits
        Rsp0Ready = 0;
        Req0Valid = 1; Req0Ctrl = 5'd1; Req0A = 32'd100; Req0B = 32'd23;
        Req1Valid = 1; Req1Ctrl = 5'd3; Req1A = 32'hF0F0; Req1B = 32'hFF00;
        @(negedge Clk);
        chk("bp_req0_ready", 32'(Req0Ready), 32'd1);
        chk("bp_req1_ready", 32'(Req1Ready), 32'd0);
        step();
        Req0Valid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_rsp0_valid", 32'(Rsp0Valid), 32'd1);
            chk("bp_req1_held", 32'(Req1Ready), 32'd0);
            chk("bp_result_stable", RspResult, 32'd123);
            step();
        end
        Rsp0Ready = 1;
        @(negedge Clk);
        chk("bp_no_same_cycle_grant", 32'(Req1Ready), 32'd0);
        step();
        @(negedge Clk);
        chk("bp_req1_granted", 32'(Req1Ready), 32'd1);
        step();
        Req1Valid = 0;
        step(); step(); step();

        // Reset during EXEC discards the operation and restores priority
        Req0Valid = 1; Req0Ctrl = 5'd1; Req0A = 32'd1; Req0B = 32'd2;
        @(negedge Clk);
        chk("rx_req0_ready", 32'(Req0Ready), 32'd1);
        step();
        Req0Valid = 0; Reset = 1;
        step();
        Reset = 0; Req0Valid = 1; Req1Valid = 1;
        @(negedge Clk);
        chk("rx_rsp0_valid", 32'(Rsp0Valid), 32'd0);
        chk("rx_rsp1_valid", 32'(Rsp1Valid), 32'd0);
        chk("rx_result", RspResult, 32'd0);
        chk("rx_req0_first", 32'(Req0Ready), 32'd1);
        chk("rx_req1_waits", 32'(Req1Ready), 32'd0);
        step();
        Req0Valid = 0; Req1Valid = 0;
        step(); step(); step();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            Reset     = ($urandom_range(0, 149) == 0);
            Req0Valid = ($urandom_range(0, 2) != 0);
            Req1Valid = ($urandom_range(0, 2) != 0);
            Req0Ctrl  = CTRL_W'($urandom_range(0, 6));
            Req1Ctrl  = CTRL_W'($urandom_range(0, 6));
            Req0A     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            Req0B     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            Req1A     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            Req1B     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            Rsp0Ready = ($urandom_range(0, 3) != 0);
            Rsp1Ready = ($urandom_range(0, 3) != 0);
            step();
        end
        Reset = 0; Req0Valid = 0; Req1Valid = 0; Rsp0Ready = 1; Rsp1Ready = 1;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
